// File: rtl/fpu_sched_if.sv
// Requester, shared-FPU and response signals of the FPU scheduler.
// The slave modport is the scheduler side; master is the environment side.
interface fpu_sched_if #(
    parameter int unsigned BIT_SIZE = 15
);
    localparam int unsigned DW = BIT_SIZE + 1;

    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2:0]    req_op0;
    logic [2:0]    req_op1;
    logic [1:0]    req_rmode0;
    logic [1:0]    req_rmode1;
    logic [DW-1:0] req_opa0;
    logic [DW-1:0] req_opb0;
    logic [DW-1:0] req_opa1;
    logic [DW-1:0] req_opb1;

    logic [2:0]    fpu_op;
    logic [1:0]    fpu_rmode;
    logic [DW-1:0] fpu_opa;
    logic [DW-1:0] fpu_opb;
    logic [DW-1:0] fpu_out;
    logic [7:0]    fpu_flags;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic [7:0]    rsp_flags;
    logic          rsp_err;

    modport slave (
        input  req_valid, req_op0, req_op1, req_rmode0, req_rmode1,
               req_opa0, req_opb0, req_opa1, req_opb1,
               fpu_out, fpu_flags, rsp_ready,
        output req_ready, fpu_op, fpu_rmode, fpu_opa, fpu_opb,
               rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err
    );

    modport master (
        output req_valid, req_op0, req_op1, req_rmode0, req_rmode1,
               req_opa0, req_opb0, req_opa1, req_opb1,
               fpu_out, fpu_flags, rsp_ready,
        input  req_ready, fpu_op, fpu_rmode, fpu_opa, fpu_opb,
               rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err
    );
endinterface

// File: rtl/fpu_sched.sv
// Two-requester round-robin scheduler for one shared multi-cycle FPU.
// One operation in flight; illegal op codes are answered without using the FPU.
module fpu_sched #(
    parameter int unsigned BIT_SIZE    = 15,
    parameter int unsigned FPU_LATENCY = 4,
    parameter int unsigned DIV_LATENCY = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    fpu_sched_if.slave  bus
);
    localparam int unsigned DW    = BIT_SIZE + 1;
    localparam int unsigned MAX_L = (DIV_LATENCY > FPU_LATENCY) ? DIV_LATENCY : FPU_LATENCY;
    localparam int unsigned CW    = $clog2(MAX_L + 1);
    localparam logic [CW-1:0] FPU_CNT = CW'(FPU_LATENCY - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_served;
    logic          grant;
    logic          accept;
    logic          op_legal;
    logic [1:0]    ready_c;
    logic [CW-1:0] cnt;

    logic [2:0]    sel_op;
    logic [1:0]    sel_rmode;
    logic [DW-1:0] sel_opa;
    logic [DW-1:0] sel_opb;

    logic [2:0]    fpu_op_q;
    logic [1:0]    fpu_rmode_q;
    logic [DW-1:0] fpu_opa_q;
    logic [DW-1:0] fpu_opb_q;
    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [DW-1:0] rsp_data_q;
    logic [7:0]    rsp_flags_q;
    logic          rsp_err_q;

    // Arbitration: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant = 1'b0;
        case (bus.req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_served;
            default: grant = 1'b0;
        endcase
        sel_op    = grant ? bus.req_op0 : bus.req_op0;
        sel_op    = grant ? bus.req_op1    : bus.req_op0;
        sel_rmode = grant ? bus.req_rmode1 : bus.req_rmode0;
        sel_opa   = grant ? bus.req_opa1   : bus.req_opa0;
        sel_opb   = grant ? bus.req_opb1   : bus.req_opb0;
        op_legal  = (sel_op <= 3'd5);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = op_legal ? BUSY : RESP;
            BUSY: if (cnt == '0) state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted even though state already reads IDLE
    always_comb begin
        accept  = 1'b0;
        ready_c = 2'b00;
        if (state == IDLE && rst_n && (|bus.req_valid)) begin
            accept  = 1'b1;
            ready_c = grant ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served <= 1'b1;
            cnt         <= '0;
            fpu_op_q    <= '0;
            fpu_rmode_q <= '0;
            fpu_opa_q   <= '0;
            fpu_opb_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= (state_nxt == RESP);
            if (accept) begin
                last_served <= grant;
                rsp_id_q    <= grant;
                fpu_op_q    <= sel_op;
                fpu_rmode_q <= sel_rmode;
                fpu_opa_q   <= sel_opa;
                fpu_opb_q   <= sel_opb;
                cnt         <= (sel_op == 3'd3) ? DIV_CNT : FPU_CNT;
                if (!op_legal) begin
                    rsp_data_q  <= '0;
                    rsp_flags_q <= '0;
                    rsp_err_q   <= 1'b1;
                end
            end else if (state == BUSY) begin
                if (cnt == '0) begin
                    rsp_data_q  <= bus.fpu_out;
                    rsp_flags_q <= bus.fpu_flags;
                    rsp_err_q   <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.fpu_op    = fpu_op_q;
    assign bus.fpu_rmode = fpu_rmode_q;
    assign bus.fpu_opa   = fpu_opa_q;
    assign bus.fpu_opb   = fpu_opb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
